// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receive engine with synchroniser, false-start rejection,
// parity/framing/overrun flags and a valid/ready output register. Optional: UART_RX_MAJORITY_VOTE_EN.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    input  logic                 rx_enable,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] HALF_M1   = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_M1   = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  LAST_DATA = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  LAST_STOP = CNT_W'(STOP_BITS - 1);
    localparam logic              PAR_ODD   = (PARITY == 1);
    localparam logic              PAR_EN    = (PARITY != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [CNT_W-1:0]     bit_q, bit_d;
    logic                 par_acc_q, par_acc_d;
    logic                 ferr_q, ferr_d;
    logic                 sync1_q, sync2_q, prev_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 shift_en;
    logic                 frame_done;
    logic                 sample;
    logic                 start_edge;
    logic                 par_err_next;

    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 parity_err_q;
    logic                 frame_err_q;
    logic                 overrun_q;

`ifdef UART_RX_MAJORITY_VOTE_EN
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // prev_q / sync2_q / sync1_q are the line at target-1, target and target+1 as seen
    // from the sample cycle, so the vote needs no extra latency.
    assign sample = maj3(prev_q, sync2_q, sync1_q);
`else
    assign sample = sync2_q;
`endif

    assign start_edge   = prev_q & ~sync2_q;
    assign par_err_next = PAR_EN & (par_acc_q != PAR_ODD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            par_acc_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            par_acc_q <= par_acc_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q + 1'b1;
        bit_d      = bit_q;
        par_acc_d  = par_acc_q;
        ferr_d     = ferr_q;
        shift_en   = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                baud_d    = '0;
                bit_d     = '0;
                par_acc_d = 1'b0;
                ferr_d    = 1'b0;
                if (rx_enable && start_edge) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_q == HALF_M1) begin
                    baud_d  = '0;
                    state_d = sample ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (baud_q == FULL_M1) begin
                    baud_d    = '0;
                    shift_en  = 1'b1;
                    par_acc_d = par_acc_q ^ sample;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_q == FULL_M1) begin
                    baud_d    = '0;
                    par_acc_d = par_acc_q ^ sample;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_q == FULL_M1) begin
                    baud_d = '0;
                    ferr_d = ferr_q | ~sample;
                    // Leaving at mid-stop lets a start bit right after the stop bit be caught.
                    if (bit_q == LAST_STOP) begin
                        frame_done = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE && !rx_enable) begin
            state_d    = S_IDLE;
            baud_d     = '0;
            shift_en   = 1'b0;
            frame_done = 1'b0;
        end
    end

    // Shift register is fully overwritten before every use, so it carries no reset.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            if (MSB_FIRST != 0) begin
                shift_q <= {shift_q[DATA_BITS-2:0], sample};
            end else begin
                shift_q <= {sample, shift_q[DATA_BITS-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (frame_done) begin
            rx_data_q    <= shift_q;
            rx_valid_q   <= 1'b1;
            parity_err_q <= par_err_next;
            frame_err_q  <= ferr_d;
            overrun_q    <= rx_valid_q & ~rx_ready;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: two receivers (8N1 LSB-first, 7E2 MSB-first) driven from
// frame bit lists built by a reference model; directed cases then random frames.
module tb_uart_rx_param;
    localparam int C = 16;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       rx_a  = 1'b1;
    logic       rx_b  = 1'b1;
    logic       en_a  = 1'b1;
    logic       en_b  = 1'b1;
    logic       rdy_a = 1'b0;
    logic       rdy_b = 1'b0;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       vld_a, vld_b, perr_a, perr_b, ferr_a, ferr_b, ovr_a, ovr_b, busy_a, busy_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rise_a = -1;
    int rise_b = -1;
    logic vp_a = 1'b0;
    logic vp_b = 1'b0;
    bit   pend [2];

    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .MSB_FIRST(0)) dut_a (
        .clk(clk), .rst(rst), .rx_in(rx_a), .rx_enable(en_a), .rx_data(data_a), .rx_valid(vld_a),
        .rx_ready(rdy_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a), .busy(busy_a)
    );

    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .MSB_FIRST(1)) dut_b (
        .clk(clk), .rst(rst), .rx_in(rx_b), .rx_enable(en_b), .rx_data(data_b), .rx_valid(vld_b),
        .rx_ready(rdy_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Cycle stamp of each rx_valid rising edge, used for latency checks.
    always @(negedge clk) begin
        if (vld_a && !vp_a) rise_a = cyc;
        if (vld_b && !vp_b) rise_b = cyc;
        vp_a = vld_a;
        vp_b = vld_b;
    end

    function automatic int f_db(input int w);  return (w == 0) ? 8 : 7; endfunction
    function automatic int f_par(input int w); return (w == 0) ? 0 : 2; endfunction
    function automatic int f_sb(input int w);  return (w == 0) ? 1 : 2; endfunction
    function automatic bit f_msb(input int w); return (w != 0);         endfunction

    function automatic logic [31:0] g_vld(input int w);  return 32'((w == 0) ? vld_a : vld_b);   endfunction
    function automatic logic [31:0] g_pe(input int w);   return 32'((w == 0) ? perr_a : perr_b); endfunction
    function automatic logic [31:0] g_fe(input int w);   return 32'((w == 0) ? ferr_a : ferr_b); endfunction
    function automatic logic [31:0] g_ovr(input int w);  return 32'((w == 0) ? ovr_a : ovr_b);   endfunction
    function automatic logic [31:0] g_busy(input int w); return 32'((w == 0) ? busy_a : busy_b); endfunction
    function automatic logic [31:0] g_data(input int w);
        return (w == 0) ? 32'(data_a) : 32'(data_b);
    endfunction
    function automatic logic [31:0] g_all(input int w);
        if (w == 0) return {18'd0, vld_a, perr_a, ferr_a, ovr_a, busy_a, 1'b0, data_a};
        return {18'd0, vld_b, perr_b, ferr_b, ovr_b, busy_b, 2'b00, data_b};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic set_line(input int w, input logic v);
        if (w == 0) rx_a = v; else rx_b = v;
    endtask
    task automatic set_en(input int w, input logic v);
        if (w == 0) en_a = v; else en_b = v;
    endtask
    task automatic set_rdy(input int w, input logic v);
        if (w == 0) rdy_a = v; else rdy_b = v;
    endtask

    // abort_kind: 0 none, 1 drop rx_enable, 2 assert reset; applied mid-way through bit abort_bit.
    task automatic send_frame(input int w, input logic [8:0] word, input bit pflip, input int stop_low,
                              input int gap, input int abort_bit, input int abort_kind,
                              output bit exp_pe, output bit exp_fe, output int c0);
        int         db;
        int         par;
        logic [8:0] wm;
        logic       pbit;
        logic       bits[$];
        bit         chk_busy;
        db     = f_db(w);
        par    = f_par(w);
        wm     = word & 9'((1 << db) - 1);
        exp_pe = 1'b0;
        exp_fe = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < db; i++) bits.push_back(f_msb(w) ? wm[db-1-i] : wm[i]);
        if (par != 0) begin
            pbit   = (^wm) ^ (par == 1) ^ pflip;
            exp_pe = (((^wm) ^ pbit) != (par == 1));
            bits.push_back(pbit);
        end
        for (int s = 0; s < f_sb(w); s++) begin
            bits.push_back((s == stop_low) ? 1'b0 : 1'b1);
            if (s == stop_low) exp_fe = 1'b1;
        end
        c0       = 0;
        chk_busy = 1'b0;
        for (int i = 0; i < bits.size(); i++) begin
            for (int j = 0; j < C; j++) begin
                @(negedge clk);
                if (chk_busy) begin
                    check_val("abort_busy_after", g_busy(w), 0);
                    chk_busy = 1'b0;
                end
                if (i == 0 && j == 0) c0 = cyc;
                if (j == 0) set_line(w, bits[i]);
                if (i == abort_bit && j == C / 2) begin
                    if (abort_kind == 1) begin
                        check_val("abort_busy_before", g_busy(w), 1);
                        set_en(w, 1'b0);
                        chk_busy = 1'b1;
                    end else if (abort_kind == 2) begin
                        rst = 1'b0;
                        #1;
                        check_val("rst_async_a", g_all(0), 0);
                        check_val("rst_async_b", g_all(1), 0);
                    end
                end
            end
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            set_line(w, 1'b1);
        end
        if (abort_kind == 1) set_en(w, 1'b1);
        if (abort_kind == 2) rst = 1'b1;
    endtask

    task automatic expect_word(input int w, input logic [8:0] word, input bit pe, input bit fe,
                               input bit ov, input int c0, input bit chk_lat);
        int n;
        n = f_db(w) + ((f_par(w) != 0) ? 1 : 0) + f_sb(w);
        check_val($sformatf("valid_%0d", w), g_vld(w), 1);
        check_val($sformatf("data_%0d", w), g_data(w), 32'(word) & ((32'd1 << f_db(w)) - 1));
        check_val($sformatf("parity_err_%0d", w), g_pe(w), 32'(pe));
        check_val($sformatf("frame_err_%0d", w), g_fe(w), 32'(fe));
        check_val($sformatf("overrun_%0d", w), g_ovr(w), 32'(ov));
        if (chk_lat)
            check_val($sformatf("latency_%0d", w), 32'(((w == 0) ? rise_a : rise_b) - c0),
                      32'(C / 2 + 3 + C * n));
        pend[w] = 1'b1;
    endtask

    task automatic accept(input int w);
        @(negedge clk);
        set_rdy(w, 1'b1);
        @(negedge clk);
        set_rdy(w, 1'b0);
        check_val($sformatf("accept_valid_%0d", w), g_vld(w), 0);
        check_val($sformatf("accept_overrun_%0d", w), g_ovr(w), 0);
        pend[w] = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        bit   pe, fe, pf, was;
        int   c0, w, sl, gap, vcnt, bcnt;
        logic [8:0] word;
        pend[0] = 1'b0;
        pend[1] = 1'b0;

        idle(3);
        check_val("reset_a", g_all(0), 0);
        check_val("reset_b", g_all(1), 0);
        rst = 1'b1;
        idle(5);

        send_frame(0, 9'hA5, 1'b0, -1, 4, -1, 0, pe, fe, c0);
        expect_word(0, 9'hA5, pe, fe, 1'b0, c0, 1'b1);
        idle(5);
        check_val("hold_valid", g_vld(0), 1);
        check_val("hold_data", g_data(0), 'hA5);
        accept(0);

        send_frame(1, 9'h35, 1'b0, -1, 4, -1, 0, pe, fe, c0);
        expect_word(1, 9'h35, 1'b0, 1'b0, 1'b0, c0, 1'b1);
        accept(1);
        send_frame(1, 9'h35, 1'b1, -1, 4, -1, 0, pe, fe, c0);
        expect_word(1, 9'h35, 1'b1, 1'b0, 1'b0, c0, 1'b1);
        accept(1);

        // 3-clk glitch: START must reject it after half a bit.
        @(negedge clk);
        rx_a = 1'b0;
        vcnt = 0;
        bcnt = 0;
        for (int k = 1; k <= 3 * C; k++) begin
            @(negedge clk);
            if (k == 3) rx_a = 1'b1;
            if (busy_a) bcnt++;
            if (vld_a) vcnt++;
        end
        check_val("glitch_busy_cycles", 32'(bcnt), C / 2);
        check_val("glitch_no_valid", 32'(vcnt), 0);

        // Stop bit low, then line held low (break) for two frame times.
        send_frame(0, 9'h3C, 1'b0, 0, 0, -1, 0, pe, fe, c0);
        expect_word(0, 9'h3C, 1'b0, 1'b1, 1'b0, c0, 1'b1);
        accept(0);
        vcnt = 0;
        bcnt = 0;
        for (int k = 0; k < 20 * C; k++) begin
            @(negedge clk);
            if (vld_a) vcnt++;
            if (busy_a) bcnt++;
        end
        check_val("break_no_valid", 32'(vcnt), 0);
        check_val("break_no_busy", 32'(bcnt), 0);
        rx_a = 1'b1;
        idle(2 * C);
        send_frame(0, 9'h5A, 1'b0, -1, 4, -1, 0, pe, fe, c0);
        expect_word(0, 9'h5A, 1'b0, 1'b0, 1'b0, c0, 1'b1);
        accept(0);

        // Two back-to-back frames without acceptance.
        send_frame(0, 9'h11, 1'b0, -1, 0, -1, 0, pe, fe, c0);
        expect_word(0, 9'h11, pe, fe, 1'b0, c0, 1'b1);
        send_frame(0, 9'h22, 1'b0, -1, 4, -1, 0, pe, fe, c0);
        expect_word(0, 9'h22, pe, fe, 1'b1, c0, 1'b0);
        accept(0);

        // rx_enable dropped during data bit 4.
        send_frame(0, 9'h6B, 1'b0, -1, 4, 5, 1, pe, fe, c0);
        idle(2);
        check_val("abort_no_valid", g_vld(0), 0);

        for (int k = 0; k < 24; k++) begin
            w    = int'($urandom_range(0, 1));
            word = 9'($urandom);
            pf   = (w == 1) && ($urandom_range(0, 3) == 0);
            sl   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, f_sb(w) - 1)) : -1;
            gap  = int'($urandom_range(0, 3));
            if (sl == f_sb(w) - 1) gap = gap + 3;
            was  = pend[w];
            send_frame(w, word, pf, sl, gap, -1, 0, pe, fe, c0);
            expect_word(w, word, pe, fe, was, c0, !was);
            if ($urandom_range(0, 1) == 1) accept(w);
        end

        // Reset in the middle of a frame while a word is pending.
        send_frame(0, 9'h77, 1'b0, -1, 4, -1, 0, pe, fe, c0);
        expect_word(0, 9'h77, pe, fe, pend[0], c0, 1'b0);
        send_frame(0, 9'h99, 1'b0, -1, 4, 3, 2, pe, fe, c0);
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        idle(2);
        check_val("post_rst_valid", g_vld(0), 0);
        send_frame(0, 9'h42, 1'b0, -1, 4, -1, 0, pe, fe, c0);
        expect_word(0, 9'h42, 1'b0, 1'b0, 1'b0, c0, 1'b1);
        accept(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
